// File: rtl/myriadrf_usb_tx_deframer.sv
// myriadrf_usb_tx_deframer
// Host-to-radio USB byte stream deframer. Hunts for the sync byte, reads a
// length header (samples per packet) and packs 3-byte groups into 24-bit
// {I[11:0],Q[11:0]} samples for the TX sample path. Counts good packets
// (wrapping) and framing errors (saturating).
module myriadrf_usb_tx_deframer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 128
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        enable_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [23:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        pkt_done_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t      state_r;
  logic [1:0]  idx_r;
  logic [7:0]  rem_r;
  logic [7:0]  b0_r;
  logic [7:0]  b1_r;

  logic [7:0]  max_len_s;
  logic        ready_s;
  logic        accept_s;
  logic        load_s;
  logic        last_s;
  logic        len_bad_s;
  logic        err_inc_s;

  assign max_len_s = 8'(MAX_LEN);

  // Byte-side readiness: the third byte of a group waits for room in the output register
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_HUNT:    ready_s = enable_i;
      ST_LEN:     ready_s = 1'b1;
      ST_PAYLOAD: begin
        if (idx_r == 2'd2) begin
          ready_s = !m_valid_o || m_ready_i;
        end else begin
          ready_s = 1'b1;
        end
      end
      default:    ready_s = 1'b0;
    endcase
  end

  // Ready is held low while reset is asserted so no byte is taken during reset
  assign s_ready_o = ready_s & ~wb_rst;
  assign accept_s  = s_valid_i & s_ready_o;

  // Decode of the accepted byte: sample load, end of packet and framing errors
  always_comb begin
    load_s    = 1'b0;
    last_s    = 1'b0;
    len_bad_s = 1'b0;
    err_inc_s = 1'b0;
    if ((s_data_i == 8'd0) || (s_data_i > max_len_s)) begin
      len_bad_s = 1'b1;
    end else begin
      len_bad_s = 1'b0;
    end
    if (accept_s) begin
      case (state_r)
        ST_HUNT:    err_inc_s = (s_data_i != SYNC_BYTE);
        ST_LEN:     err_inc_s = len_bad_s;
        ST_PAYLOAD: begin
          load_s = (idx_r == 2'd2);
          last_s = (idx_r == 2'd2) && (rem_r == 8'd1);
        end
        default:    err_inc_s = 1'b0;
      endcase
    end else begin
      load_s    = 1'b0;
      last_s    = 1'b0;
      err_inc_s = 1'b0;
    end
  end

  // Packet parser FSM: advances only on accepted bytes, no timeout
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r <= ST_HUNT;
      idx_r   <= 2'd0;
      rem_r   <= 8'd0;
      b0_r    <= 8'd0;
      b1_r    <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        ST_HUNT: begin
          if (s_data_i == SYNC_BYTE) begin
            state_r <= ST_LEN;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_LEN: begin
          if (len_bad_s) begin
            state_r <= ST_HUNT;
          end else begin
            rem_r   <= s_data_i;
            idx_r   <= 2'd0;
            state_r <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          case (idx_r)
            2'd0: begin
              b0_r  <= s_data_i;
              idx_r <= 2'd1;
            end
            2'd1: begin
              b1_r  <= s_data_i;
              idx_r <= 2'd2;
            end
            2'd2: begin
              idx_r <= 2'd0;
              rem_r <= rem_r - 8'd1;
              if (rem_r == 8'd1) begin
                state_r <= ST_HUNT;
              end else begin
                state_r <= ST_PAYLOAD;
              end
            end
            default: idx_r <= 2'd0;
          endcase
        end
        default: state_r <= ST_HUNT;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Output sample register: holds until taken, reloads back-to-back without a bubble
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      m_data_o   <= 24'd0;
      m_valid_o  <= 1'b0;
      pkt_done_o <= 1'b0;
    end else begin
      pkt_done_o <= last_s;
      if (load_s) begin
        m_data_o  <= {b0_r, b1_r, s_data_i};
        m_valid_o <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end else begin
        m_valid_o <= m_valid_o;
      end
    end
  end

  // Statistics: good packets wrap, framing errors saturate
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      pkt_cnt_o <= 16'd0;
      err_cnt_o <= 16'd0;
    end else begin
      if (last_s) begin
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end else begin
        pkt_cnt_o <= pkt_cnt_o;
      end
      if (err_inc_s && (err_cnt_o != 16'hFFFF)) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end else begin
        err_cnt_o <= err_cnt_o;
      end
    end
  end

endmodule
